// File: rtl/sync_filter.sv
// Multi-channel input conditioner: N-stage synchroniser then a per-channel stability filter.
// o/rise/fall are registered; a level change reaches o N_STAGES+FILTER_CYCLES edges after capture.
module sync_filter #(
    parameter int           W             = 1,
    parameter int           N_STAGES      = 2,
    parameter int           FILTER_CYCLES = 4,
    parameter logic [W-1:0] RESET_VAL     = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i,
    output logic [W-1:0] o,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);
    localparam int            CW       = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    if (N_STAGES < 2) begin : g_bad_stages
        $fatal(1, "sync_filter: N_STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $fatal(1, "sync_filter: FILTER_CYCLES must be at least 1");
    end

    for (genvar k = 0; k < W; k++) begin : g_ch
        (* keep = "true" *) logic [N_STAGES-1:0] r_sync;
        logic [CW-1:0] r_cnt;
        logic          r_o;
        logic          r_rise;
        logic          r_fall;
        logic          w_s;

        assign w_s     = r_sync[N_STAGES-1];
        assign o[k]    = r_o;
        assign rise[k] = r_rise;
        assign fall[k] = r_fall;

        // Pure shift chain: nothing may sit between the metastability flops.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= {N_STAGES{RESET_VAL[k]}};
            end else begin
                r_sync <= {r_sync[N_STAGES-2:0], i[k]};
            end
        end

        // Counter clears whenever s returns to o, so short excursions leave no trace.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt  <= '0;
                r_o    <= RESET_VAL[k];
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_s == r_o) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_o    <= w_s;
                    r_cnt  <= '0;
                    r_rise <= w_s;
                    r_fall <= ~w_s;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter: four parameterisations share one stimulus bus and reset;
// a run-length reference model feeds a per-edge scoreboard, plus directed edge/strobe checks.
module tb_sync_filter;
    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] tb_in = '0;

    logic [3:0] o_a, rise_a, fall_a;
    logic [3:0] o_b, rise_b, fall_b;
    logic [0:0] o_c, rise_c, fall_c;
    logic [7:0] o_d, rise_d, fall_d;

    always #5 clk = ~clk;

    sync_filter #(.W(4), .N_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(4'b1010)) dut_a (
        .clk(clk), .rst(rst), .i(tb_in[3:0]), .o(o_a), .rise(rise_a), .fall(fall_a));
    sync_filter #(.W(4), .N_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(4'b0000)) dut_b (
        .clk(clk), .rst(rst), .i(tb_in[3:0]), .o(o_b), .rise(rise_b), .fall(fall_b));
    sync_filter #(.W(1), .N_STAGES(3), .FILTER_CYCLES(1), .RESET_VAL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .i(tb_in[0:0]), .o(o_c), .rise(rise_c), .fall(fall_c));
    sync_filter #(.W(8), .N_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(8'h00)) dut_d (
        .clk(clk), .rst(rst), .i(tb_in), .o(o_d), .rise(rise_d), .fall(fall_d));

    int         sel = 0;
    logic [7:0] obs_o, obs_rise, obs_fall;

    always_comb begin
        obs_o    = '0;
        obs_rise = '0;
        obs_fall = '0;
        case (sel)
            0: begin obs_o = {4'b0, o_a}; obs_rise = {4'b0, rise_a}; obs_fall = {4'b0, fall_a}; end
            1: begin obs_o = {4'b0, o_b}; obs_rise = {4'b0, rise_b}; obs_fall = {4'b0, fall_b}; end
            2: begin obs_o = {7'b0, o_c}; obs_rise = {7'b0, rise_c}; obs_fall = {7'b0, fall_c}; end
            default: begin obs_o = o_d; obs_rise = rise_d; obs_fall = fall_d; end
        endcase
    end

    typedef struct packed {
        logic [7:0] o;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_hist[$];
    int         m_n, m_f;
    logic [7:0] m_rv, m_mask, m_o;
    int         errors = 0;
    int         checks = 0;

    // Synchronised value seen by the filter just before edge t (edges counted from reset release).
    function automatic logic [7:0] s_before(input int t);
        if (t - m_n >= 0) return m_hist[t - m_n];
        return m_rv;
    endfunction

    // Output follows s once the last FILTER_CYCLES pre-edge samples all disagree with it.
    task automatic model_push(input logic [7:0] in);
        exp_t       e;
        int         t;
        logic [7:0] sv, pv;
        bit         stable;
        m_hist.push_back(in & m_mask);
        t  = m_hist.size() - 1;
        e  = '0;
        sv = s_before(t);
        for (int ch = 0; ch < 8; ch++) begin
            if (m_mask[ch] && (sv[ch] != m_o[ch])) begin
                stable = 1'b1;
                for (int j = 1; j < m_f; j++) begin
                    pv = s_before(t - j);
                    if (pv[ch] != sv[ch]) stable = 1'b0;
                end
                if (stable) begin
                    m_o[ch]    = sv[ch];
                    e.rise[ch] = sv[ch];
                    e.fall[ch] = ~sv[ch];
                end
            end
        end
        e.o = m_o;
        sb.push_back(e);
    endtask

    task automatic configure(input int s, input int n, input int f, input logic [7:0] rv,
                             input logic [7:0] mask);
        sel = s; m_n = n; m_f = f; m_rv = rv & mask; m_mask = mask;
    endtask

    task automatic model_reset();
        m_hist.delete();
        sb.delete();
        m_o = m_rv;
    endtask

    task automatic apply_reset(input logic [7:0] in);
        @(negedge clk);
        rst = 1'b1;
        tb_in = in;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Called at a negedge: drive, predict, then sample at the following negedge.
    task automatic step(input logic [7:0] in);
        tb_in = in;
        model_push(in);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        configure(0, 2, 4, 8'h0A, 8'h0F);
        @(negedge clk);
        rst = 1'b1;
        tb_in = 8'h05;
        #1;
        checks++;
        if (obs_o !== 8'h0A) begin
            errors++; $display("FAIL reset_async: o=%h required 0a", obs_o);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({obs_o, obs_rise, obs_fall} !== {8'h0A, 8'h00, 8'h00}) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: o=%h rise=%h fall=%h required 0a/00/00",
                         c, obs_o, obs_rise, obs_fall);
            end
        end
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            step(8'h05);
            e = sb.pop_front();
            checks++;
            if ({obs_o, obs_rise, obs_fall} !== e) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %h required %h", k,
                         {obs_o, obs_rise, obs_fall}, e);
            end
            if (k == 4) begin
                checks++;
                if (obs_o !== 8'h0A) begin
                    errors++; $display("FAIL reset_release_early: o=%h required 0a", obs_o);
                end
            end
            if (k == 5) begin
                checks++;
                if ({obs_o, obs_rise, obs_fall} !== {8'h05, 8'h05, 8'h0A}) begin
                    errors++;
                    $display("FAIL reset_release_edge5: o=%h rise=%h fall=%h required 05/05/0a",
                             obs_o, obs_rise, obs_fall);
                end
            end
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        configure(0, 2, 4, 8'h0A, 8'h0F);
        for (int k = 0; k < 4; k++) begin
            step(8'h00);
            e = sb.pop_front();
            checks++;
            if ({obs_o, obs_rise, obs_fall} !== e) begin
                errors++;
                $display("FAIL midcount_pre edge %0d: got %h required %h", k,
                         {obs_o, obs_rise, obs_fall}, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({obs_o, obs_rise, obs_fall} !== {8'h0A, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL midcount_async: o=%h rise=%h fall=%h required 0a/00/00",
                     obs_o, obs_rise, obs_fall);
        end
        @(negedge clk);
        checks++;
        if ({obs_o, obs_rise, obs_fall} !== {8'h0A, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL midcount_hold: o=%h rise=%h fall=%h required 0a/00/00",
                     obs_o, obs_rise, obs_fall);
        end
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            step(8'h00);
            e = sb.pop_front();
            checks++;
            if ({obs_o, obs_rise, obs_fall} !== e) begin
                errors++;
                $display("FAIL midcount_post edge %0d: got %h required %h", k,
                         {obs_o, obs_rise, obs_fall}, e);
            end
            if (k == 4) begin
                checks++;
                if (obs_o !== 8'h0A) begin
                    errors++; $display("FAIL midcount_early: o=%h required 0a", obs_o);
                end
            end
            if (k == 5) begin
                checks++;
                if ({obs_o, obs_fall} !== {8'h00, 8'h0A}) begin
                    errors++;
                    $display("FAIL midcount_edge5: o=%h fall=%h required 00/0a", obs_o, obs_fall);
                end
            end
        end
    endtask

    task automatic test_step_latency();
        exp_t e;
        int   first_chg;
        int   n_rise;
        configure(1, 2, 4, 8'h00, 8'h0F);
        apply_reset(8'h00);
        for (int k = 0; k < 3; k++) begin
            step(8'h00);
            e = sb.pop_front();
            checks++;
            if ({obs_o, obs_rise, obs_fall} !== e) begin
                errors++;
                $display("FAIL step_idle edge %0d: got %h required %h", k,
                         {obs_o, obs_rise, obs_fall}, e);
            end
        end
        first_chg = -1;
        n_rise = 0;
        for (int k = 0; k < 12; k++) begin
            step(8'h03);
            e = sb.pop_front();
            checks++;
            if ({obs_o, obs_rise, obs_fall} !== e) begin
                errors++;
                $display("FAIL step_rise edge %0d: got %h required %h", k,
                         {obs_o, obs_rise, obs_fall}, e);
            end
            if (first_chg < 0 && obs_o !== 8'h00) first_chg = k;
            if (obs_rise !== 8'h00) n_rise++;
        end
        checks++;
        if (first_chg != 5) begin
            errors++; $display("FAIL step_latency: o changed at edge %0d required 5", first_chg);
        end
        checks++;
        if (n_rise != 1) begin
            errors++; $display("FAIL step_rise_once: %0d rise cycles required 1", n_rise);
        end
        for (int k = 0; k < 12; k++) begin
            step(8'h00);
            e = sb.pop_front();
            checks++;
            if ({obs_o, obs_rise, obs_fall} !== e) begin
                errors++;
                $display("FAIL step_fall edge %0d: got %h required %h", k,
                         {obs_o, obs_rise, obs_fall}, e);
            end
            if (k == 5) begin
                checks++;
                if ({obs_o, obs_rise, obs_fall} !== {8'h00, 8'h00, 8'h03}) begin
                    errors++;
                    $display("FAIL step_fall_edge5: o=%h rise=%h fall=%h required 00/00/03",
                             obs_o, obs_rise, obs_fall);
                end
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   n_rise, n_fall, n_high;
        configure(1, 2, 4, 8'h00, 8'h0F);
        for (int p = 0; p < 2; p++) begin
            n_rise = 0; n_fall = 0; n_high = 0;
            for (int k = 0; k < 18; k++) begin
                step((k < ((p == 0) ? 3 : 5)) ? 8'h01 : 8'h00);
                e = sb.pop_front();
                checks++;
                if ({obs_o, obs_rise, obs_fall} !== e) begin
                    errors++;
                    $display("FAIL glitch_p%0d edge %0d: got %h required %h", p, k,
                             {obs_o, obs_rise, obs_fall}, e);
                end
                if (obs_rise[0] === 1'b1) n_rise++;
                if (obs_fall[0] === 1'b1) n_fall++;
                if (obs_o[0] === 1'b1) n_high++;
            end
            checks++;
            if (p == 0 && (n_rise != 0 || n_fall != 0 || n_high != 0)) begin
                errors++;
                $display("FAIL glitch_short: rise=%0d fall=%0d high=%0d required 0/0/0",
                         n_rise, n_fall, n_high);
            end else if (p == 1 && (n_rise != 1 || n_fall != 1 || n_high != 5)) begin
                errors++;
                $display("FAIL glitch_long: rise=%0d fall=%0d high=%0d required 1/1/5",
                         n_rise, n_fall, n_high);
            end
        end
    endtask

    task automatic test_no_filter();
        exp_t e;
        logic exp_o;
        configure(2, 3, 1, 8'h00, 8'h01);
        apply_reset(8'h00);
        for (int k = 0; k < 20; k++) begin
            step((k % 2 == 0) ? 8'h01 : 8'h00);
            e = sb.pop_front();
            checks++;
            if ({obs_o, obs_rise, obs_fall} !== e) begin
                errors++;
                $display("FAIL nofilt edge %0d: got %h required %h", k,
                         {obs_o, obs_rise, obs_fall}, e);
            end
            checks++;
            if ((obs_rise[0] & obs_fall[0]) !== 1'b0) begin
                errors++; $display("FAIL nofilt_both edge %0d: rise=1 fall=1 required exclusive", k);
            end
            if (k >= 3) begin
                exp_o = ((k - 3) % 2 == 0);
                checks++;
                if ({obs_o[0], obs_rise[0] ^ obs_fall[0]} !== {exp_o, 1'b1}) begin
                    errors++;
                    $display("FAIL nofilt_delay edge %0d: o=%b strobe=%b required %b/1", k,
                             obs_o[0], obs_rise[0] ^ obs_fall[0], exp_o);
                end
            end
        end
    endtask

    task automatic test_channel_independence();
        exp_t       e;
        int         st[8];
        int         wd[8];
        logic [7:0] v;
        configure(3, 2, 4, 8'h00, 8'hFF);
        apply_reset(8'h00);
        for (int ch = 0; ch < 8; ch++) begin
            st[ch] = $urandom_range(0, 20);
            wd[ch] = $urandom_range(1, 8);
        end
        wd[0] = 3;
        wd[7] = 5;
        for (int k = 0; k < 40; k++) begin
            for (int ch = 0; ch < 8; ch++) v[ch] = (k >= st[ch]) && (k < st[ch] + wd[ch]);
            step(v);
            e = sb.pop_front();
            checks++;
            if ({obs_o, obs_rise, obs_fall} !== e) begin
                errors++;
                $display("FAIL indep edge %0d: got %h required %h", k,
                         {obs_o, obs_rise, obs_fall}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_step_latency();
        test_glitch();
        test_no_filter();
        test_channel_independence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_filter.md
# sync_filter

Parametrised multi-channel input conditioner for signals that arrive asynchronously to `clk`, such as buttons, GPIO inputs and status lines from other clock domains. Each channel passes through an N-stage flop synchroniser, then a per-channel stability filter. The filter only updates the output after the synchronised value has been stable for a programmable number of cycles. Single-cycle rise and fall strobes are produced alongside the filtered level. The block sits at the boundary of any single-clock subsystem and replaces ad-hoc synchroniser-plus-debounce logic.

## Interface
- `W`, default 1: number of independent channels.
- `N_STAGES`, default 2: synchroniser depth; must be ≥2.
- `FILTER_CYCLES`, default 4: number of consecutive cycles the synchronised value must differ from `o` before `o` follows it; must be ≥1. A value of 1 means no filtering.
- `RESET_VAL`, default `{W{1'b0}}`: reset value of the synchroniser flops and of `o`.
- Elaboration: `N_STAGES < 2` or `FILTER_CYCLES < 1` causes a fatal error.

Ports:
- `clk` input, 1 bit: the only clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `i` input, W bits: asynchronous raw inputs, one per channel.
- `o` output, W bits: synchronised, filtered level, registered.
- `rise` output, W bits: one-cycle strobe when `o[k]` goes 0→1, registered.
- `fall` output, W bits: one-cycle strobe when `o[k]` goes 1→0, registered.

## Operation
- Each channel k is fully independent; no logic is shared between channels except `clk` and `rst`.
- Synchroniser:
  - A shift chain of `N_STAGES` flops.
  - `s[k]` is the output of the last stage.
  - The synchroniser flops carry a keep attribute and contain no logic between stages.
- Filter counter:
  - `cnt[k]` has width `$clog2(FILTER_CYCLES)`, with a minimum of 1 bit.
  - On each rising edge of `clk`:
    - If `s[k] == o[k]`: `cnt[k]` is set to 0.
    - Else if `cnt[k] == FILTER_CYCLES-1`: `o[k]` is set to `s[k]` and `cnt[k]` is set to 0. `rise[k]` is set to `s[k]` and `fall[k]` to `!s[k]`.
    - Else: `cnt[k]` is set to `cnt[k]+1`.
  - `rise[k]` and `fall[k]` are 0 on every edge where `o[k]` does not change.
- Glitch rejection: any excursion of `s[k]` away from `o[k]` lasting fewer than `FILTER_CYCLES` consecutive cycles is discarded, because the counter clears as soon as `s[k]` returns.
- Counter bound: the counter never exceeds `FILTER_CYCLES-1`, so it has no wrap-around.
- Strobe exclusivity: `rise[k]` and `fall[k]` are never both high. Each strobe lasts exactly one cycle, because `o[k]` cannot change on two consecutive edges unless `FILTER_CYCLES == 1`.
- Reset, while `rst` is high, applies asynchronously and regardless of `clk`:
  - Synchroniser flops and `o` are set to `RESET_VAL`.
  - `cnt` is set to 0.
  - `rise` and `fall` are set to 0.
- Reset mid-operation: any count in progress is lost. After release, a pending change requires the full latency again.
- No strobe on reset: `o` being forced to `RESET_VAL` by reset does not generate `rise` or `fall`.

## Timing
- Edge numbering: edge 0 is the first rising edge of `clk` at which the new level of `i[k]` is captured.
  - `s[k]` reflects the new level after edge `N_STAGES-1`.
  - `o[k]` and the strobe update at edge `N_STAGES+FILTER_CYCLES-1`.
- Latency from capture to output is therefore `N_STAGES+FILTER_CYCLES` edges, counting edge 0. Capture itself may be delayed by one cycle through metastability; the bench must tolerate ±1 cycle on asynchronous stimulus only.
- Strobes: `rise` and `fall` are high for exactly the cycle in which `o` holds its new value for the first time.
- Pulse acceptance: an input pulse that is stable for at least `FILTER_CYCLES+1` cycles of `clk` is always reproduced on `o`. A pulse shorter than `FILTER_CYCLES-1` cycles never is.
- Reset release: the first functional edge after `rst` falls behaves as edge 0 for any input that differs from `RESET_VAL`.

## Test plan
- **Reset:** with `W=4` and `RESET_VAL=4'b1010`, hold `rst` high with `i=4'b0101` for 10 cycles -> `o=4'b1010` and `rise=fall=0` throughout. Release `rst` -> `o=4'b0101` after 6 edges, with `rise=4'b0101` and `fall=4'b1010` for one cycle.
- **Step latency:** with `N_STAGES=2`, `FILTER_CYCLES=4` and `RESET_VAL=0`, drive `i` 0→`4'b0011` synchronously before edge 0 -> `o` changes at edge 5 exactly and `rise=4'b0011` for one cycle only. Then drive `i`→0 -> `fall=4'b0011` 6 edges later.
- **Glitch rejection:** a 3-cycle high pulse on `i[0]` (`FILTER_CYCLES=4`) -> `o[0]` stays 0 with no strobes. A 5-cycle pulse -> `o[0]` is high for 5 cycles, with one `rise` and one `fall`.
- **No filtering:** with `FILTER_CYCLES=1` and `N_STAGES=3`, toggle `i[0]` every cycle -> `o[0]` is `i[0]` delayed by 3 edges. `rise` and `fall` alternate each cycle and are never both high.
- **Channel independence:** with `W=8`, toggle each channel at a random time with a random pulse width -> `o` matches a per-channel reference model and channels do not cross-couple.
- **Reset mid-count:** assert `rst` asynchronously while `cnt[0]=2` -> `o=RESET_VAL` immediately and no strobe. After release, with `i` held at the new value, `o` changes only after the full 6 edges.
